jtpang_rom_arb: RTL and testbench
=================================

JTPANG_ROM_ARB -- requirements
Module: jtpang_rom_arb

Interface
REQ-001 SHALL have parameter OBJ_OFFSET, default 22'h00_0000, word offset of the object ROM region in memory.
REQ-002 SHALL have parameter CHR_OFFSET, default 22'h02_0000, word offset of the tile ROM region in memory.
REQ-003 SHALL have ports, clock and reset first: rst in 1, asynchronous, active-high; clk in 1, clock.
REQ-004 SHALL have obj_cs in 1, object fetcher request.
REQ-005 SHALL have obj_addr in 17, object word address.
REQ-006 SHALL have obj_data out 32, object data.
REQ-007 SHALL have obj_ok out 1, obj_data valid for the current obj_addr.
REQ-008 SHALL have chr_cs in 1, tile fetcher request.
REQ-009 SHALL have chr_addr in 19, tile word address.
REQ-010 SHALL have chr_data out 32, tile data.
REQ-011 SHALL have chr_ok out 1, chr_data valid for the current chr_addr.
REQ-012 SHALL have mem_req out 1, memory request level.
REQ-013 SHALL have mem_addr out 22, memory word address.
REQ-014 SHALL have mem_ack in 1, one-cycle request accepted.
REQ-015 SHALL have mem_dok in 1, one-cycle data valid.
REQ-016 SHALL have mem_din in 32, memory read data.

Function
REQ-017 SHALL keep per requester a data register, a tag register holding the issued address, and a valid flag.
REQ-018 SHALL drive xxx_ok = xxx_cs & valid & (tag == current addr), combinationally; xxx_data = data register.
REQ-019 SHALL treat a requester as pending when xxx_cs=1 and xxx_ok=0.
REQ-020 SHALL implement the FSM states IDLE, WAIT_ACK and WAIT_DOK.
REQ-021 IDLE: when any requester is pending, SHALL latch the grant and tag, drive mem_req=1 and mem_addr=offset+zero-extended addr on the next edge, then go to WAIT_ACK.
REQ-022 WAIT_ACK: on mem_ack SHALL drop mem_req the same edge and go to WAIT_DOK.
REQ-023 WAIT_DOK: on mem_dok SHALL store mem_din into the granted data register and set its valid flag, then return to IDLE.
REQ-024 Result: minimum latency from cs to ok is 3 clk plus memory latency; a new grant is possible on the cycle after return to IDLE.
REQ-025 Arbitration SHALL be round-robin: if both requesters are pending, grant the one not granted last; if one is pending, grant it.
REQ-026 last_grant SHALL reset to chr, so obj wins the first tie.
REQ-027 An address change during a fetch SHALL NOT abort it: data is stored under the old tag, ok stays 0, and a new fetch follows.
REQ-028 cs deasserted during a fetch SHALL NOT abort it; the result is stored and ok stays 0 while cs=0.
REQ-029 mem_ack and mem_dok asserted in states other than their own SHALL be ignored.
REQ-030 Offset addition SHALL wrap modulo 2^22.
REQ-031 A stored result SHALL remain valid indefinitely; a repeat access to the same address returns ok with no memory cycle.

Reset
REQ-032 On rst, SHALL set state=IDLE, mem_req=0, mem_addr=0, both valid=0, both tags=0, both data=0, last_grant=chr.
REQ-033 Hence obj_ok=0 and chr_ok=0 during reset.
REQ-034 rst asserted mid-transaction SHALL abandon it; a late mem_dok after reset SHALL be ignored, since the FSM is in IDLE.

Structure
REQ-035 SHALL define the FSM state encoding and the grant encoding (OBJ=0, CHR=1) as constants in a shared jtpang package.
REQ-036 SHALL be one module with no sub-modules; per-requester logic SHALL be written as two instances of identical code.

Verification
REQ-037 Single request: obj_cs=1, obj_addr=17'h00100; memory acks after 2 clk and returns 32'hDEADBEEF 4 clk later -> mem_addr=22'h000100, obj_ok=1 with obj_data=32'hDEADBEEF.
REQ-038 Tie: obj and chr requested on the same cycle after reset -> obj served first (mem_addr=OBJ_OFFSET+addr), then chr (mem_addr=22'h020000+chr_addr).
REQ-039 Round-robin: both requesters continuously changing addresses -> grants alternate obj, chr, obj, chr over 8 fetches.
REQ-040 Address change: obj_addr changes 5->6 while in WAIT_DOK -> no ok for 5 while addr=6, then a second fetch at 6 and ok; returning addr to 5 gives no ok because the tag was overwritten.
REQ-041 Hit: repeat chr_addr=19'h1234 after a completed fetch -> chr_ok=1 the same cycle and mem_req stays 0.
REQ-042 Reset mid-op: rst in WAIT_DOK, then a stray mem_dok -> valid flags stay 0 and mem_req=0.

Source files
------------

// File: rtl/jtpang_pkg.sv
// Shared constants for the jtpang ROM arbiter: FSM state and grant encodings,
// plus the bus widths used by both requester ports and the memory side.
package jtpang_pkg;

    localparam int unsigned NREQ = 2;   // requesters: object and tile fetchers
    localparam int unsigned AW   = 22;  // memory word address width
    localparam int unsigned TW   = 19;  // widest requester address (tile side)
    localparam int unsigned DW   = 32;  // data width

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_WAIT_DOK = 2'd2
    } state_t;

    // Grant value doubles as the index of the requester slot.
    typedef enum logic {
        GNT_OBJ = 1'b0,
        GNT_CHR = 1'b1
    } grant_t;

endpackage

// File: rtl/jtpang_rom_arb.sv
// Two-requester ROM arbiter with a one-word cache per requester.
// Each requester keeps the last fetched word, the address it was issued for and
// a valid flag; a hit answers combinationally, a miss queues a memory fetch.
// Fetches are never aborted by the requester; grants alternate on contention.
module jtpang_rom_arb
    import jtpang_pkg::*;
#(
    parameter logic [AW-1:0] OBJ_OFFSET = 22'h00_0000,
    parameter logic [AW-1:0] CHR_OFFSET = 22'h02_0000
) (
    input  logic          rst,
    input  logic          clk,

    input  logic          obj_cs,
    input  logic [16:0]   obj_addr,
    output logic [DW-1:0] obj_data,
    output logic          obj_ok,

    input  logic          chr_cs,
    input  logic [TW-1:0] chr_addr,
    output logic [DW-1:0] chr_data,
    output logic          chr_ok,

    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic          mem_dok,
    input  logic [DW-1:0] mem_din
);

    // Requester ports gathered into slot-indexed vectors.
    logic [NREQ-1:0]         req_cs;
    logic [NREQ-1:0]         req_ok;
    logic [NREQ-1:0]         req_pend;
    logic [NREQ-1:0][TW-1:0] req_addr;
    logic [NREQ-1:0][AW-1:0] req_off;
    logic [NREQ-1:0][DW-1:0] req_data;

    assign req_cs[GNT_OBJ]   = obj_cs;
    assign req_cs[GNT_CHR]   = chr_cs;
    assign req_addr[GNT_OBJ] = {{(TW-17){1'b0}}, obj_addr};
    assign req_addr[GNT_CHR] = chr_addr;
    assign req_off[GNT_OBJ]  = OBJ_OFFSET;
    assign req_off[GNT_CHR]  = CHR_OFFSET;

    assign obj_ok   = req_ok[GNT_OBJ];
    assign obj_data = req_data[GNT_OBJ];
    assign chr_ok   = req_ok[GNT_CHR];
    assign chr_data = req_data[GNT_CHR];

    state_t        state_q, state_d;
    grant_t        gnt_q, gnt_d;     // slot granted most recently (also the active one)
    grant_t        sel;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          issue;            // a fetch is launched on this edge
    logic          store;            // returning data lands on this edge

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    // Round-robin pick: on a tie take the slot not served last.
    always_comb begin
        if (&req_pend) begin
            sel = (gnt_q == GNT_OBJ) ? GNT_CHR : GNT_OBJ;
        end else if (req_pend[GNT_CHR]) begin
            sel = GNT_CHR;
        end else begin
            sel = GNT_OBJ;
        end
    end

    // Fetch sequencer: issue, wait for acceptance, wait for data.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        gnt_d      = gnt_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        issue      = 1'b0;
        store      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_pend) begin
                    issue      = 1'b1;
                    gnt_d      = sel;
                    mem_req_d  = 1'b1;
                    mem_addr_d = req_off[sel] + {{(AW-TW){1'b0}}, req_addr[sel]};
                    state_d    = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_WAIT_DOK;
                end
            end
            ST_WAIT_DOK: begin
                if (mem_dok) begin
                    store   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            state_q    <= ST_IDLE;
            gnt_q      <= GNT_CHR;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // One identical cache slot per requester.
    for (genvar i = 0; i < NREQ; i++) begin : g_req
        localparam grant_t ME = grant_t'(i);

        logic [DW-1:0] data_q, data_d;
        logic [TW-1:0] tag_q, tag_d;
        logic          valid_q, valid_d;

        assign req_ok[ME]   = req_cs[ME] & valid_q & (tag_q == req_addr[ME]);
        assign req_pend[ME] = req_cs[ME] & ~req_ok[ME];
        assign req_data[ME] = data_q;

        // Launch retags and invalidates the slot; returning data revalidates it.
        always_comb begin
            data_d  = data_q;
            tag_d   = tag_q;
            valid_d = valid_q;
            if (issue && gnt_d == ME) begin
                tag_d   = req_addr[ME];
                valid_d = 1'b0;
            end
            if (store && gnt_q == ME) begin
                data_d  = mem_din;
                valid_d = 1'b1;
            end
        end

        // Slot registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                // NOTE: the data word is reset too, so outputs are defined from reset rather than left as X.
                data_q  <= '0;
                tag_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                tag_q   <= tag_d;
                valid_q <= valid_d;
            end
        end
    end

endmodule

// File: tb/tb_jtpang_rom_arb.sv
// Self-checking bench for jtpang_rom_arb: a behavioural memory answers each
// request and pops the expected address from a scoreboard queue; requester
// results are compared against the memory's own data function.
module tb_jtpang_rom_arb;

    localparam logic [21:0] OBJ_OFF = 22'h00_0000;
    localparam logic [21:0] CHR_OFF = 22'h02_0000;
    localparam int ACK_DLY = 2;
    localparam int DOK_DLY = 4;

    logic        rst = 1'b1;
    logic        clk = 1'b0;
    logic        obj_cs = 1'b0;
    logic [16:0] obj_addr = '0;
    logic [31:0] obj_data;
    logic        obj_ok;
    logic        chr_cs = 1'b0;
    logic [18:0] chr_addr = '0;
    logic [31:0] chr_data;
    logic        chr_ok;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic        mem_dok = 1'b0;
    logic [31:0] mem_din = '0;

    int n_pass   = 0;
    int n_checks = 0;
    logic [21:0] exp_q[$];

    jtpang_rom_arb #(.OBJ_OFFSET(OBJ_OFF), .CHR_OFFSET(CHR_OFF)) dut (
        .rst(rst), .clk(clk),
        .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
        .chr_cs(chr_cs), .chr_addr(chr_addr), .chr_data(chr_data), .chr_ok(chr_ok),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_dok(mem_dok), .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [21:0] a);
        return (a == 22'h000100) ? 32'hDEADBEEF : {~a[9:0], a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    // Sample/drive point: just after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic probe(input int which);
        case (which)
            0: return obj_ok;
            1: return chr_ok;
            2: return mem_ack;
            3: return mem_dok;
            default: return obj_ok & chr_ok;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which);
        logic hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            tick();
            hit = probe(which);
        end
        check({tag, "_seen"}, {31'd0, hit}, 32'd1);
    endtask

    // Memory model: accept each request, verify its address, return data.
    initial begin
        logic [21:0] a;
        logic [21:0] e;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                a = mem_addr;
                if (exp_q.size() == 0) begin
                    check("mem_unexpected_fetch", {10'h3FF, a}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_addr", {10'h0, a}, {10'h0, e});
                end
                repeat (ACK_DLY - 1) @(negedge clk);
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
                repeat (DOK_DLY - 1) @(negedge clk);
                mem_din = mem_word(a);
                mem_dok = 1'b1;
                @(negedge clk);
                mem_dok = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int obj_k;
        int chr_k;

        // Reset state: outputs quiet even with requests asserted.
        obj_cs = 1'b1;
        chr_cs = 1'b1;
        tick();
        tick();
        check("rst_obj_ok", {31'd0, obj_ok}, 32'd0);
        check("rst_chr_ok", {31'd0, chr_ok}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", {10'd0, mem_addr}, 32'd0);
        check("rst_obj_data", obj_data, 32'd0);
        obj_cs = 1'b0;
        chr_cs = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Single object fetch.
        exp_q.push_back(22'h000100);
        obj_addr = 17'h00100;
        obj_cs   = 1'b1;
        wait_for("single_ok", 0);
        check("single_data", obj_data, 32'hDEADBEEF);
        obj_cs = 1'b0;
        tick();

        // Tie straight after reset: object first, then tile.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        exp_q.push_back(OBJ_OFF + 22'h000055);
        exp_q.push_back(CHR_OFF + 22'h000077);
        obj_addr = 17'h00055;
        chr_addr = 19'h00077;
        obj_cs   = 1'b1;
        chr_cs   = 1'b1;
        wait_for("tie_both_ok", 4);
        check("tie_obj_data", obj_data, mem_word(OBJ_OFF + 22'h000055));
        check("tie_chr_data", chr_data, mem_word(CHR_OFF + 22'h000077));

        // Round-robin with both requesters moving on after every result.
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(OBJ_OFF + 22'(17'h00200 + 17'(k)));
            exp_q.push_back(CHR_OFF + 22'(19'h00300 + 19'(k)));
        end
        obj_addr = 17'h00200;
        chr_addr = 19'h00300;
        obj_k = 0;
        chr_k = 0;
        for (int c = 0; c < 400 && (obj_k < 4 || chr_k < 4); c++) begin
            tick();
            if (obj_ok && obj_k < 4) begin
                check("rr_obj_data", obj_data, mem_word(OBJ_OFF + 22'(obj_addr)));
                obj_k++;
                if (obj_k < 4) obj_addr = obj_addr + 17'd1;
            end
            if (chr_ok && chr_k < 4) begin
                check("rr_chr_data", chr_data, mem_word(CHR_OFF + 22'(chr_addr)));
                chr_k++;
                if (chr_k < 4) chr_addr = chr_addr + 19'd1;
            end
        end
        check("rr_obj_count", obj_k, 4);
        check("rr_chr_count", chr_k, 4);
        check("rr_queue_drained", exp_q.size(), 0);

        // Address change while waiting for data.
        chr_cs = 1'b0;
        exp_q.push_back(OBJ_OFF + 22'd5);
        exp_q.push_back(OBJ_OFF + 22'd6);
        obj_addr = 17'd5;
        wait_for("chg_ack", 2);
        tick();
        obj_addr = 17'd6;
        wait_for("chg_dok", 3);
        tick();
        check("chg_stale_no_ok", {31'd0, obj_ok}, 32'd0);
        wait_for("chg_ok6", 0);
        check("chg_data6", obj_data, mem_word(OBJ_OFF + 22'd6));
        obj_addr = 17'd5;
        #1;
        check("chg_old_tag_gone", {31'd0, obj_ok}, 32'd0);
        obj_cs = 1'b0;
        tick();

        // Hit on a repeat tile address.
        exp_q.push_back(CHR_OFF + 22'h001234);
        chr_addr = 19'h01234;
        chr_cs   = 1'b1;
        wait_for("hit_first", 1);
        check("hit_first_data", chr_data, mem_word(22'h021234));
        chr_cs = 1'b0;
        tick();
        tick();
        chr_cs = 1'b1;
        #1;
        check("hit_ok", {31'd0, chr_ok}, 32'd1);
        check("hit_no_req", {31'd0, mem_req}, 32'd0);
        repeat (3) tick();
        check("hit_still_no_req", {31'd0, mem_req}, 32'd0);
        check("hit_data", chr_data, mem_word(22'h021234));
        chr_cs = 1'b0;
        tick();

        // Reset during WAIT_DOK, then the late data strobe.
        exp_q.push_back(OBJ_OFF);
        obj_addr = 17'd0;
        obj_cs   = 1'b1;
        wait_for("mid_ack", 2);
        tick();
        rst    = 1'b1;
        obj_cs = 1'b0;
        tick();
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        rst = 1'b0;
        wait_for("mid_stray_dok", 3);
        tick();
        check("mid_req_after", {31'd0, mem_req}, 32'd0);
        chr_addr = 19'd0;
        obj_cs   = 1'b1;
        chr_cs   = 1'b1;
        #1;
        check("mid_obj_invalid", {31'd0, obj_ok}, 32'd0);
        check("mid_chr_invalid", {31'd0, chr_ok}, 32'd0);
        obj_cs = 1'b0;
        chr_cs = 1'b0;
        repeat (3) tick();
        check("mid_idle_req", {31'd0, mem_req}, 32'd0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
